// File: rtl/feature_window_writer.sv
// rtl/feature_window_writer.sv - builds KxK windows from a raster pixel stream and writes them to the feature BRAM
// One output row is handed to the consumer at a time via row_ready/row_ack.
module feature_window_writer #(
  parameter int IN_WIDTH    = 8,
  parameter int IMAGE       = 32,
  parameter int KERNEL_SIZE = 5,
  localparam int AWIDTH     = $clog2(IMAGE)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [IN_WIDTH-1:0]                       pixel_in,
  input  logic                                      pixel_valid,
  output logic                                      pixel_ready,
  output logic                                      bram_we,
  output logic [AWIDTH-1:0]                         bram_addr,
  output logic [KERNEL_SIZE*KERNEL_SIZE*IN_WIDTH-1:0] bram_data,
  output logic                                      row_ready,
  input  logic                                      row_ack,
  output logic [AWIDTH-1:0]                         out_row,
  output logic                                      done
);

  localparam int K       = KERNEL_SIZE;
  localparam int OUT_DIM = IMAGE - K + 1;
  localparam logic [AWIDTH-1:0] KM1      = AWIDTH'(K - 1);
  localparam logic [AWIDTH-1:0] LAST_COL = AWIDTH'(IMAGE - 1);
  localparam logic [AWIDTH-1:0] LAST_OUT = AWIDTH'(OUT_DIM - 1);
  localparam logic [AWIDTH-1:0] ONE      = AWIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ROW_WAIT, S_DONE} state_t;

  state_t state_q, state_d;

  logic [AWIDTH-1:0] col_q, row_q, out_row_q;
  logic              bram_we_q;
  logic [AWIDTH-1:0] bram_addr_q;

  logic [IN_WIDTH-1:0] win_q [K][K];
  logic [IN_WIDTH-1:0] lb_q  [K-1][IMAGE];
  logic [IN_WIDTH-1:0] col_vec [K];

  logic accept, in_win, row_end, start_go;

  assign accept   = pixel_valid && (state_q == S_RUN);
  assign in_win   = (row_q >= KM1) && (col_q >= KM1);
  assign row_end  = accept && (col_q == LAST_COL) && (row_q >= KM1);
  assign start_go = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_RUN;
      S_RUN:      if (row_end) state_d = S_ROW_WAIT;
      S_ROW_WAIT: if (row_ack) state_d = (out_row_q == LAST_OUT) ? S_DONE : S_RUN;
      S_DONE:     if (start) state_d = S_RUN;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pixel_ready = (state_q == S_RUN);
    row_ready   = (state_q == S_ROW_WAIT);
    done        = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q       <= '0;
      row_q       <= '0;
      out_row_q   <= '0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
    end else begin
      bram_we_q <= accept && in_win;
      if (accept && in_win) bram_addr_q <= col_q - KM1;
      if (row_end) out_row_q <= row_q - KM1;
      if (start_go) begin
        col_q <= '0;
        row_q <= '0;
      end else if (accept) begin
        if (col_q == LAST_COL) begin
          col_q <= '0;
          row_q <= row_q + ONE;
        end else begin
          col_q <= col_q + ONE;
        end
      end
    end
  end

  // Column entering the window: K-1 buffered rows (oldest first) plus the live pixel.
  always_comb begin
    for (int r = 0; r < K - 1; r++) col_vec[r] = lb_q[r][col_q];
    col_vec[K-1] = pixel_in;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < K - 1; i++) lb_q[i][col_q] <= col_vec[i+1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win_q[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win_q[r][c] <= win_q[r][c+1];
        win_q[r][K-1] <= col_vec[r];
      end
    end
  end

  always_comb begin
    bram_data = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        bram_data[(r*K+c)*IN_WIDTH +: IN_WIDTH] = win_q[r][c];
  end

  assign bram_we   = bram_we_q;
  assign bram_addr = bram_addr_q;
  assign out_row   = out_row_q;

endmodule

// File: tb/tb_feature_window_writer.sv
// tb/tb_feature_window_writer.sv - scoreboard bench for feature_window_writer
// Driver pushes expected writes/rows; a negedge monitor pops and compares.
module tb_feature_window_writer;

  localparam int IW  = 8;
  localparam int IMG = 32;
  localparam int K   = 5;
  localparam int AW  = 5;
  localparam int OD  = IMG - K + 1;
  localparam int DW  = K * K * IW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [IW-1:0] pixel_in = '0;
  logic          pixel_valid = 1'b0;
  logic          pixel_ready;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_data;
  logic          row_ready;
  logic          row_ack = 1'b0;
  logic [AW-1:0] out_row;
  logic          done;

  feature_window_writer #(.IN_WIDTH(IW), .IMAGE(IMG), .KERNEL_SIZE(K)) dut (
    .clk(clk), .rst(rst), .start(start), .pixel_in(pixel_in),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_data(bram_data), .row_ready(row_ready),
    .row_ack(row_ack), .out_row(out_row), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cy; logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { int cy; logic [AW-1:0] row; } rw_t;
  wr_t wq[$];
  rw_t rq[$];

  int n_cmp = 0;
  int n_fail = 0;
  int n_wr = 0;
  bit first_chk = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] pix(input int y, input int x, input int s);
    return IW'((y * IMG + x + s) & 255);
  endfunction

  function automatic logic [DW-1:0] win(input int y, input int x, input int s);
    logic [DW-1:0] w;
    w = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w[(r*K+c)*IW +: IW] = pix(y - K + 1 + r, x - K + 1 + c, s);
    return w;
  endfunction

  // Monitor
  initial begin
    wr_t e;
    rw_t q;
    logic prev_rr;
    prev_rr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_rr = 1'b0;
      end else begin
        if (bram_we) begin
          n_wr++;
          if (wq.size() == 0) begin
            chk("unexpected_write", 1, 0);
          end else begin
            e = wq.pop_front();
            chk("wr_cycle", cyc, e.cy);
            chk("wr_addr", bram_addr, e.addr);
            chk_w("wr_data", bram_data, e.data);
          end
          if (first_chk) begin
            first_chk = 1'b0;
            chk("first_addr", bram_addr, 0);
            chk("first_px00", bram_data[7:0], 'h00);
            chk("first_px44", bram_data[24*8 +: 8], 'h84);
          end
        end
        if (row_ready && !prev_rr) begin
          if (rq.size() == 0) begin
            chk("unexpected_row", 1, 0);
          end else begin
            q = rq.pop_front();
            chk("row_cycle", cyc, q.cy);
            chk("out_row", out_row, q.row);
          end
        end
        if (row_ready) chk("ready_low_in_wait", pixel_ready, 0);
        prev_rr = row_ready;
      end
    end
  end

  task automatic run_frame(input int seed, input int gap, input int abort_row, input bit misc);
    int  y, x, wait_cnt, rows, budget, dly;
    bit  acked, fin, v;
    y = 0; x = 0; wait_cnt = 0; rows = 0; budget = 20000;
    acked = 1'b0; fin = 1'b0;
    n_wr = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ready", pixel_ready, 1);
    chk("start_done_clear", done, 0);
    while (!fin && budget > 0) begin
      row_ack = 1'b0;
      start = 1'b0;
      if (acked) begin
        acked = 1'b0;
        if (rows == OD) begin
          chk("done_set", done, 1);
          chk("done_ready", pixel_ready, 0);
          fin = 1'b1;
        end else begin
          chk("resume_ready", pixel_ready, 1);
        end
      end
      if (fin) break;
      if (row_ready) begin
        pixel_valid = 1'b1;
        pixel_in = 8'hA5;
        dly = (rows % 2 == 0) ? 10 : 0;
        if (wait_cnt >= dly) begin
          row_ack = 1'b1;
          acked = 1'b1;
          rows++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        if (y == abort_row && x == 10) begin
          #2 rst = 1'b0;
          #1;
          chk("abort_ready", pixel_ready, 0);
          chk("abort_we", bram_we, 0);
          chk("abort_row_ready", row_ready, 0);
          chk("abort_done", done, 0);
          chk_w("abort_data", bram_data, '0);
          wq.delete();
          rq.delete();
          pixel_valid = 1'b0;
          @(negedge clk);
          @(negedge clk);
          rst = 1'b1;
          return;
        end
        if (misc) begin
          start   = (y == 6 && x < 3);
          row_ack = (y == 7 && x < 3);
        end
        v = (y < IMG) && ($urandom_range(99) >= gap);
        pixel_valid = v;
        pixel_in = pix(y, x, seed);
        if (v && pixel_ready) begin
          if (y >= K - 1 && x >= K - 1)
            wq.push_back(wr_t'{cyc + 1, AW'(x - K + 1), win(y, x, seed)});
          if (y >= K - 1 && x == IMG - 1)
            rq.push_back(rw_t'{cyc + 1, AW'(y - K + 1)});
          x++;
          if (x == IMG) begin
            x = 0;
            y++;
          end
        end
      end
      @(negedge clk);
      budget--;
    end
    pixel_valid = 1'b0;
    row_ack = 1'b0;
    chk("frame_finished", fin, 1);
    chk("write_count", n_wr, OD * OD);
  endtask

  initial begin
    rst = 1'b0;
    pixel_valid = 1'b1;
    pixel_in = 8'h3C;
    repeat (3) @(negedge clk);
    chk("rst_ready", pixel_ready, 0);
    chk("rst_we", bram_we, 0);
    chk("rst_row_ready", row_ready, 0);
    chk("rst_done", done, 0);
    chk_w("rst_data", bram_data, '0);
    rst = 1'b1;
    pixel_valid = 1'b0;
    @(negedge clk);
    chk("idle_ready", pixel_ready, 0);

    first_chk = 1'b1;
    run_frame(0, 0, -1, 1'b0);
    run_frame(0, 50, -1, 1'b1);
    run_frame(7, 0, 10, 1'b0);
    run_frame(3, 20, -1, 1'b0);

    repeat (3) @(negedge clk);
    chk("final_done", done, 1);
    chk("pending_writes", wq.size(), 0);
    chk("pending_rows", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
